// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial word I/O block.
//   state_e   : frame sequencer states
//   cnt_width : width of the frame counter, which must reach 2K+LAT-1 for any LAT up to K
package bit_serial_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned k);
        return $clog2(2 * k + k);
    endfunction

endpackage

// File: rtl/bit_serial_sipo.sv
// Serial-in capture register. New bits enter at the MSB and the register shifts right.
// After W enables, the first bit captured sits at the LSB.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear (has priority over enable)
//   enable     : shift din in this cycle
//   din        : serial input bit
//   data       : register contents
module bit_serial_sipo #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         din,
    output logic [W-1:0] data
);

    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (enable) begin
            data_d = {din, data_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/bit_serial_word_io.sv
// Word-parallel front end for a bit-serial multiplier. An accepted operand pair is sent
// LSB first on x/y for a 2K-cycle frame, zero-extended in the upper half. The product is
// collected from p with an offset of LAT cycles and presented in parallel.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake, a_in/b_in unsigned K-bit operands
//   x, y                : serial operand bits
//   first_bit/last_bit  : frame cycle 0 / frame cycle 2K-1 markers
//   p                   : serial product bit from the multiplier
//   out_valid/out_ready : product handshake, prod_out 2K-bit product
module bit_serial_word_io
    import bit_serial_pkg::*;
#(
    parameter int unsigned K   = 8,
    parameter int unsigned LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   a_in,
    input  logic [K-1:0]   b_in,
    output logic           x,
    output logic           y,
    output logic           first_bit,
    output logic           last_bit,
    input  logic           p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*K-1:0] prod_out
);

    localparam int unsigned   CW         = cnt_width(K);
    localparam logic [CW-1:0] SendLast   = CW'(2 * K - 1);
    localparam logic [CW-1:0] SendPenult = CW'(2 * K - 2);
    localparam logic [CW-1:0] DrainLast  = CW'(2 * K + LAT - 1);
    localparam logic [CW-1:0] LatC       = CW'(LAT);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Operands shift right each SEND cycle, so the LSB is the current serial bit and the
    // registers run out to zero, giving the zero extension for free.
    logic [K-1:0]     a_q, a_d;
    logic [K-1:0]     b_q, b_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [2*K-1:0]   prod_q, prod_d;
    logic [2*K-1:0]   cap_data;
    logic             accept;
    logic             busy;
    logic             cap_en;

    assign in_ready = (state_q == StIdle) && !reset;
    assign busy     = (state_q == StSend) || (state_q == StDrain);

    // Product bit i arrives at frame cycle i+LAT, so the first LAT cycles carry nothing.
    if (LAT == 0) begin : g_lat0
        assign cap_en = busy;
    end else begin : g_lat
        assign cap_en = busy && (cnt_q >= LatC);
    end

    bit_serial_sipo #(
        .W(2 * K)
    ) u_sipo (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .enable(cap_en),
        .din   (p),
        .data  (cap_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        first_d = 1'b0;
        last_d  = 1'b0;
        prod_d  = prod_q;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = StSend;
                    cnt_d   = '0;
                    a_d     = a_in;
                    b_d     = b_in;
                    first_d = 1'b1;
                end
            end
            StSend: begin
                cnt_d  = cnt_q + CW'(1);
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                last_d = (cnt_q == SendPenult);
                if (cnt_q == SendLast) begin
                    state_d = (LAT == 0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DrainLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // The final product bit is still on p when DONE is entered; fold it in here so the
        // output register only ever holds complete products.
        if ((state_d == StDone) && (state_q != StDone)) begin
            prod_d = {p, cap_data[2*K-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            first_q <= first_d;
            last_q  <= last_d;
            prod_q  <= prod_d;
        end
    end

    assign x         = a_q[0];
    assign y         = b_q[0];
    assign first_bit = first_q;
    assign last_bit  = last_q;
    assign out_valid = (state_q == StDone);
    assign prod_out  = prod_q;

endmodule

// File: doc/bit_serial_word_io.md
BIT_SERIAL_WORD_IO -- requirements
Module: bit_serial_word_io

Interface
REQ-001 SHALL have parameter K, default 8: operand width in bits; frame length is 2K cycles.
REQ-002 SHALL have parameter LAT, default 1, range 0..K: cycles from an x/y bit to the matching p bit at the attached serial multiplier.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block accepts an operand pair.
REQ-007 a_in  input  K  multiplicand, unsigned.
REQ-008 b_in  input  K  multiplier, unsigned.
REQ-009 x  output  1  serial multiplicand bit, LSB first.
REQ-010 y  output  1  serial multiplier bit, LSB first.
REQ-011 first_bit  output  1  high on frame cycle 0 only.
REQ-012 last_bit  output  1  high on frame cycle 2K-1 only.
REQ-013 p  input  1  serial product bit from the multiplier.
REQ-014 out_valid  output  1  product available.
REQ-015 out_ready  input  1  consumer accepts the product.
REQ-016 prod_out  output  2K  unsigned product a_in*b_in.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, DRAIN, DONE.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready, latch a_in/b_in, clear cycle counter, go to SEND.
REQ-019 SEND lasts exactly 2K cycles, counter c = 0..2K-1, registered outputs.
REQ-020 In SEND cycle c<K: x=a[c], y=b[c]; cycle c>=K: x=0, y=0 (zero extension).
REQ-021 first_bit=1 iff SEND and c=0; last_bit=1 iff SEND and c=2K-1; both 0 in all other states.
REQ-022 Product bit i SHALL be sampled from p at frame cycle i+LAT, for i=0..2K-1, into a right-shifting 2K-bit register (new bit enters MSB), so bit 0 ends at LSB.
REQ-023 After c=2K-1: LAT=0 -> DONE directly; LAT>0 -> DRAIN for exactly LAT cycles, capturing remaining bits, then DONE.
REQ-024 DRAIN: x=y=0, first_bit=last_bit=0.
REQ-025 DONE: out_valid=1, prod_out stable; on out_ready go to IDLE next cycle.
REQ-026 in_ready SHALL be 0 in SEND, DRAIN, DONE; in_valid ignored there.
REQ-027 out_valid SHALL be 0 outside DONE; prod_out holds last captured value outside DONE.
REQ-028 Minimum latency accept-to-out_valid: 2K+LAT+1 cycles; earliest next accept: one cycle after the out_valid&out_ready cycle.
REQ-029 out_ready held low SHALL hold DONE indefinitely with no change on any output.
REQ-030 a_in/b_in changes after acceptance SHALL not affect the frame in progress.

Reset
REQ-031 reset asserted SHALL immediately force IDLE, counters 0, operand and product registers 0.
REQ-032 Reset values: in_ready=1 once reset deasserts (0 while asserted), x=0, y=0, first_bit=0, last_bit=0, out_valid=0, prod_out=0.
REQ-033 reset mid-frame SHALL abort the frame; no partial product is ever presented.

Structure
REQ-034 Shared package bit_serial_pkg SHALL hold the FSM state enum and a function returning counter width $clog2(2K+K).
REQ-035 One sub-module bit_serial_sipo (2K-bit serial-in capture register with enable and clear) SHALL be instantiated; all else inline.

Verification (K=8, LAT=1 unless stated)
REQ-036 a=3, b=5 accepted -> first_bit on cycle 0, last_bit on cycle 15, x=1,1,0.., y=1,0,1,0..; with model multiplier prod_out=0x000F.
REQ-037 a=0xFF, b=0xFF -> prod_out=0xFE01, out_valid exactly 18 cycles after accept.
REQ-038 out_ready low 10 cycles in DONE -> out_valid, prod_out unchanged; in_ready stays 0; in_valid pulses ignored.
REQ-039 reset asserted at SEND cycle 5 -> all outputs zero same cycle, in_ready=1 after release, next frame a=2,b=7 gives 0x000E.
REQ-040 Back-to-back: in_valid, out_ready held 1, three pairs (1,1),(0,0xAA),(0x80,2) -> products 0x0001, 0x0000, 0x0100 in order, no frame overlap.
REQ-041 LAT=0 and LAT=3 variants of REQ-036 -> identical products, DRAIN length 0 and 3.
